tx_fifo_wc: RTL and testbench
=============================

TX_FIFO_WC -- requirements
Module: tx_fifo_wc

Interface
REQ-001 Parameter DEPTH, default 6, number of wide entries; any integer >= 2, power of two not required.
REQ-002 Parameter LANES, default 4, number of WORD_W words per wide entry; any integer >= 1.
REQ-003 Parameter WORD_W, default 32, read word width in bits.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 wr_en  input  1  push one wide entry.
REQ-007 wr_data  input  LANES*WORD_W  wide entry; lane 0 = most-significant WORD_W bits.
REQ-008 rd_en  input  1  pop one word.
REQ-009 rd_data  output  WORD_W  current head word, first-word fall-through.
REQ-010 full  output  1  all DEPTH entries occupied.
REQ-011 empty  output  1  no words held.
REQ-012 word_count  output  $clog2(DEPTH*LANES+1)  words held.
REQ-013 flush  input  1  present only with TX_FIFO_FLUSH_EN (REQ-031).

Function
REQ-014 State: tail_ptr and head_ptr (0..DEPTH-1), head_lane (0..LANES-1), entry_count (0..DEPTH); all registered.
REQ-015 Accepted write (wr_en & !full): wr_data stored at entry tail_ptr, tail_ptr advances by 1, DEPTH-1 wraps to 0.
REQ-016 Write while full is dropped: no storage, pointer or count change, even with a concurrent read freeing an entry.
REQ-017 rd_data = lane head_lane of entry head_ptr, combinational from registered state; value is don't-care while empty.
REQ-018 Accepted read (rd_en & !empty): head_lane increments; at LANES-1 it returns to 0, head_ptr advances with wrap, entry frees.
REQ-019 Read while empty is ignored: no state change.
REQ-020 entry_count: +1 on accepted write only; -1 on entry-freeing read only; unchanged when both occur or neither.
REQ-021 full = (entry_count == DEPTH); empty = (entry_count == 0); both are registered-state decodes with no combinational input path.
REQ-022 word_count = entry_count*LANES - head_lane.
REQ-023 Write-to-read latency is one cycle: a write into an empty FIFO gives empty=0 and valid rd_data in the next cycle.
REQ-024 Words are delivered in order: entry order first, then lane 0 to LANES-1 within each entry.
REQ-025 Storage entries have no reset; only the written entry changes on an accepted write.

Reset
REQ-026 rst is sampled at the rising edge of clk and has priority over wr_en, rd_en and flush.
REQ-027 After reset: tail_ptr=0, head_ptr=0, head_lane=0, entry_count=0, empty=1, full=0, word_count=0.
REQ-028 Reset mid-operation discards all held data; a write in the same cycle as rst is dropped.
REQ-029 The first accepted write after reset deasserts empty in the next cycle.

Configuration
REQ-030 Macro TX_FIFO_FLUSH_EN selects the flush feature.
REQ-031 With the macro defined: flush=1 at a clock edge has the same effect as REQ-027; a concurrent write or read is dropped; flush has lower priority than rst.
REQ-032 Without the macro: the flush port does not exist, and the behaviour matches the defined case with flush held at 0.

Structure
REQ-033 Package tx_fifo_pkg holds the default constants TX_WORD_W=32, TX_LANES=4 and TX_DEPTH=6, plus a function returning the word_count width.
REQ-034 Sub-module tx_fifo_ptr implements the wrapping counter (parameter MAX, inputs clk/rst/clr/inc, output count), instanced for tail_ptr, head_ptr and head_lane.
REQ-035 The top module holds the storage array, entry_count, the flag decode and the output multiplexer.

Verification (DEPTH=6, LANES=4, WORD_W=32)
REQ-036 Reset, then write 0x00000001_00000002_00000003_00000004 -> next cycle empty=0, word_count=4, rd_data=0x00000001; four reads return 1, 2, 3, 4 in order; then empty=1.
REQ-037 Write 6 entries with no reads -> full=1, word_count=24; a 7th write is dropped; reading all 24 words returns only the first 6 entries' data.
REQ-038 Steady stream: write and read interleaved past entry 5 -> tail_ptr and head_ptr wrap 5 to 0 and data order is preserved over 20 entries.
REQ-039 full=1, head_lane=3, rd_en=1 and wr_en=1 in the same cycle -> write dropped, entry_count=5, full=0 next cycle.
REQ-040 entry_count=1, head_lane=3, rd_en=1 and wr_en=1 in the same cycle -> entry_count stays 1, empty stays 0, rd_data = lane 0 of the new entry.
REQ-041 Assert rst with 3 entries held and wr_en=1 -> next cycle empty=1, word_count=0, write lost; with TX_FIFO_FLUSH_EN defined, the same result when flush is used instead of rst.

Source files
------------

// File: rtl/tx_fifo_pkg.sv
// rtl/tx_fifo_pkg.sv - default constants and word_count width helper for the wide-in/word-out TX FIFO
package tx_fifo_pkg;

  localparam int TX_WORD_W = 32;
  localparam int TX_LANES  = 4;
  localparam int TX_DEPTH  = 6;

  function automatic int wc_width(input int depth, input int lanes);
    return $clog2(depth * lanes + 1);
  endfunction

endpackage

// File: rtl/tx_fifo_ptr.sv
// rtl/tx_fifo_ptr.sv - wrapping counter 0..MAX-1 used for the FIFO pointers and lane index
module tx_fifo_ptr #(
  parameter int MAX = 4,
  parameter int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == W'(MAX - 1)) ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/tx_fifo_wc.sv
// rtl/tx_fifo_wc.sv - wide-entry write, single-word first-word-fall-through read FIFO
// Optional synchronous flush port enabled by defining TX_FIFO_FLUSH_EN.
module tx_fifo_wc
  import tx_fifo_pkg::*;
#(
  parameter int DEPTH  = TX_DEPTH,
  parameter int LANES  = TX_LANES,
  parameter int WORD_W = TX_WORD_W
) (
  input  logic                               clk,
  input  logic                               rst,
`ifdef TX_FIFO_FLUSH_EN
  input  logic                               flush,
`endif
  input  logic                               wr_en,
  input  logic [LANES*WORD_W-1:0]            wr_data,
  input  logic                               rd_en,
  output logic [WORD_W-1:0]                  rd_data,
  output logic                               full,
  output logic                               empty,
  output logic [wc_width(DEPTH, LANES)-1:0]  word_count
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int WCW = wc_width(DEPTH, LANES);

  logic                    clr;
  logic                    wr_ok;
  logic                    rd_ok;
  logic                    entry_free;
  logic [PW-1:0]           tail_ptr;
  logic [PW-1:0]           head_ptr;
  logic [LW-1:0]           head_lane;
  logic [CW-1:0]           entry_count;
  logic [LANES*WORD_W-1:0] mem [DEPTH];
  logic [LANES*WORD_W-1:0] head_entry;
  logic [WORD_W-1:0]       lane_words [LANES];

`ifdef TX_FIFO_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  // A clearing cycle drops any concurrent push or pop.
  assign wr_ok      = wr_en && !full && !clr;
  assign rd_ok      = rd_en && !empty && !clr;
  assign entry_free = rd_ok && (head_lane == LW'(LANES - 1));

  tx_fifo_ptr #(.MAX(DEPTH), .W(PW)) u_tail (
    .clk(clk), .rst(rst), .clr(clr), .inc(wr_ok), .count(tail_ptr)
  );

  tx_fifo_ptr #(.MAX(DEPTH), .W(PW)) u_head (
    .clk(clk), .rst(rst), .clr(clr), .inc(entry_free), .count(head_ptr)
  );

  tx_fifo_ptr #(.MAX(LANES), .W(LW)) u_lane (
    .clk(clk), .rst(rst), .clr(clr), .inc(rd_ok), .count(head_lane)
  );

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[tail_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      entry_count <= '0;
    end else begin
      case ({wr_ok, entry_free})
        2'b10:   entry_count <= entry_count + CW'(1);
        2'b01:   entry_count <= entry_count - CW'(1);
        default: entry_count <= entry_count;
      endcase
    end
  end

  assign full       = (entry_count == CW'(DEPTH));
  assign empty      = (entry_count == '0);
  assign word_count = WCW'(entry_count) * WCW'(LANES) - WCW'(head_lane);

  // Lane 0 occupies the most-significant word of an entry.
  assign head_entry = mem[head_ptr];
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_words[i] = head_entry[(LANES-1-i)*WORD_W +: WORD_W];
  end
  assign rd_data = lane_words[head_lane];

endmodule

// File: tb/tb_tx_fifo_wc.sv
// tb/tb_tx_fifo_wc.sv - self-checking bench for tx_fifo_wc with word-queue reference model
module tb_tx_fifo_wc;
  import tx_fifo_pkg::*;

  localparam int DEPTH = 6;
  localparam int LANES = 4;
  localparam int WW    = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  flush = 1'b0;
  logic                  wr_en = 1'b0;
  logic [LANES*WW-1:0]   wr_data = '0;
  logic                  rd_en = 1'b0;
  logic [WW-1:0]         rd_data;
  logic                  full;
  logic                  empty;
  logic [wc_width(DEPTH, LANES)-1:0] word_count;

  int errors = 0;
  int checks = 0;
  logic [WW-1:0] model_q[$];

  tx_fifo_wc #(.DEPTH(DEPTH), .LANES(LANES), .WORD_W(WW)) dut (
    .clk(clk),
    .rst(rst),
`ifdef TX_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .full(full),
    .empty(empty),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_entries();
    return (model_q.size() + LANES - 1) / LANES;
  endfunction

  // One clock: model update from pre-edge state, then compare DUT against model.
  task automatic apply(input bit r, input bit fl, input bit w, input bit rd,
                       input logic [LANES*WW-1:0] d, input string tag);
    bit wa, ra;
    rst = r; flush = fl; wr_en = w; rd_en = rd; wr_data = d;
`ifdef TX_FIFO_FLUSH_EN
    if (r || fl) model_q.delete();
`else
    if (r) model_q.delete();
`endif
    else begin
      wa = w && (model_entries() < DEPTH);
      ra = rd && (model_q.size() > 0);
      if (ra) void'(model_q.pop_front());
      if (wa) for (int i = 0; i < LANES; i++) model_q.push_back(d[(LANES-1-i)*WW +: WW]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk({tag, "_empty"}, 64'(empty), 64'(model_q.size() == 0));
    chk({tag, "_full"}, 64'(full), 64'(model_entries() == DEPTH));
    chk({tag, "_wc"}, 64'(word_count), 64'(model_q.size()));
    if (model_q.size() > 0) chk({tag, "_rd"}, 64'(rd_data), 64'(model_q[0]));
  endtask

  function automatic logic [LANES*WW-1:0] ent(input int base);
    logic [LANES*WW-1:0] e;
    for (int i = 0; i < LANES; i++) e[(LANES-1-i)*WW +: WW] = WW'(base + i);
    return e;
  endfunction

  typedef struct {
    bit r; bit w; bit rd; logic [LANES*WW-1:0] d;
    bit e_empty; bit e_full; int e_wc; bit chk_rd; logic [WW-1:0] e_rd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1, 0, 0, '0, 1, 0, 0, 0, '0};
    vecs[1] = '{0, 1, 0, 128'h00000001_00000002_00000003_00000004, 0, 0, 4, 1, 32'h1};
    vecs[2] = '{0, 0, 1, '0, 0, 0, 3, 1, 32'h2};
    vecs[3] = '{0, 0, 1, '0, 0, 0, 2, 1, 32'h3};
    vecs[4] = '{0, 0, 1, '0, 0, 0, 1, 1, 32'h4};
    vecs[5] = '{0, 0, 1, '0, 1, 0, 0, 0, '0};
    vecs[6] = '{0, 0, 1, '0, 1, 0, 0, 0, '0};

    apply(1, 0, 0, 0, '0, "init");
    for (int v = 0; v < 7; v++) begin
      apply(vecs[v].r, 0, vecs[v].w, vecs[v].rd, vecs[v].d, $sformatf("vec%0d", v));
      chk($sformatf("tbl%0d_empty", v), 64'(empty), 64'(vecs[v].e_empty));
      chk($sformatf("tbl%0d_full", v), 64'(full), 64'(vecs[v].e_full));
      chk($sformatf("tbl%0d_wc", v), 64'(word_count), 64'(vecs[v].e_wc));
      if (vecs[v].chk_rd) chk($sformatf("tbl%0d_rd", v), 64'(rd_data), 64'(vecs[v].e_rd));
    end

    // Fill to full, then a dropped 7th write, then drain.
    apply(1, 0, 0, 0, '0, "fill_rst");
    for (int e = 0; e < DEPTH; e++) apply(0, 0, 1, 0, ent(16 * e + 100), "fill");
    chk("fill_full", 64'(full), 64'(1));
    chk("fill_wc24", 64'(word_count), 64'(24));
    apply(0, 0, 1, 0, ent(32'hDEAD0000), "fill_drop");
    for (int k = 0; k < DEPTH * LANES; k++) begin
      chk("drain_word", 64'(rd_data), 64'(16 * (k / LANES) + 100 + (k % LANES)));
      apply(0, 0, 0, 1, '0, "drain");
    end
    chk("drain_empty", 64'(empty), 64'(1));

    // Streaming past the pointer wrap over 20 entries.
    apply(1, 0, 0, 0, '0, "strm_rst");
    for (int c = 0; c < 20 * LANES + 8; c++)
      apply(0, 0, (c % LANES == 0) && (c < 20 * LANES), 1, ent(1000 + c), "strm");
    chk("strm_empty", 64'(empty), 64'(1));

    // Full with head_lane=3: concurrent write dropped, one entry freed.
    apply(1, 0, 0, 0, '0, "c39_rst");
    for (int e = 0; e < DEPTH; e++) apply(0, 0, 1, 0, ent(200 + 8 * e), "c39_fill");
    for (int k = 0; k < 3; k++) apply(0, 0, 0, 1, '0, "c39_rd");
    apply(0, 0, 1, 1, ent(32'hBAD0), "c39_both");
    chk("c39_full", 64'(full), 64'(0));
    chk("c39_wc", 64'(word_count), 64'(20));

    // One entry at head_lane=3 with concurrent write: count stays 1.
    apply(1, 0, 0, 0, '0, "c40_rst");
    apply(0, 0, 1, 0, ent(300), "c40_w");
    for (int k = 0; k < 3; k++) apply(0, 0, 0, 1, '0, "c40_rd");
    apply(0, 0, 1, 1, ent(400), "c40_both");
    chk("c40_empty", 64'(empty), 64'(0));
    chk("c40_wc", 64'(word_count), 64'(4));
    chk("c40_rd", 64'(rd_data), 64'(400));

    // Reset with held data and a concurrent write.
    for (int e = 0; e < 3; e++) apply(0, 0, 1, 0, ent(500 + 8 * e), "c41_w");
    apply(1, 0, 1, 0, ent(600), "c41_rst");
    chk("c41_empty", 64'(empty), 64'(1));
    chk("c41_wc", 64'(word_count), 64'(0));
    apply(0, 0, 1, 0, ent(700), "c41_after");
    chk("c41_first", 64'(rd_data), 64'(700));
`ifdef TX_FIFO_FLUSH_EN
    for (int e = 0; e < 2; e++) apply(0, 0, 1, 0, ent(800 + 8 * e), "fl_w");
    apply(0, 1, 1, 1, ent(900), "fl_flush");
    chk("fl_empty", 64'(empty), 64'(1));
    chk("fl_wc", 64'(word_count), 64'(0));
`endif

    // Randomized traffic against the word-queue model.
    apply(1, 0, 0, 0, '0, "rnd_rst");
    for (int c = 0; c < 3000; c++) begin
      apply(($urandom_range(0, 199) == 0), 
`ifdef TX_FIFO_FLUSH_EN
            ($urandom_range(0, 249) == 0),
`else
            1'b0,
`endif
            ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 70),
            {$urandom, $urandom, $urandom, $urandom}, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
